// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the byte-level TX/RX handshake of the SPI responder
interface spi_slave_if;
   logic       i_SPI_Clk;
   logic       i_SPI_CS_n;
   logic       i_SPI_MOSI;
   logic       o_SPI_MISO;
   logic       o_SPI_MISO_En;
   logic       i_TX_DV;
   logic [7:0] i_TX_Byte;
   logic       o_TX_Ready;
   logic       o_TX_Underrun;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
   logic       o_CS_Active;
   modport slave (
      input  i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI, i_TX_DV, i_TX_Byte,
      output o_SPI_MISO, o_SPI_MISO_En, o_TX_Ready, o_TX_Underrun, o_RX_DV, o_RX_Byte, o_CS_Active
   );
   modport master (
      output i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI, i_TX_DV, i_TX_Byte,
      input  o_SPI_MISO, o_SPI_MISO_En, o_TX_Ready, o_TX_Underrun, o_RX_DV, o_RX_Byte, o_CS_Active
   );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI responder with byte RX strobe and TX holding register
module spi_slave #(
   parameter int         SPI_MODE   = 0,
   parameter logic [7:0] DEFAULT_TX = 8'h00
) (
   input logic       i_Clk,
   input logic       i_Rst_L,
   spi_slave_if.slave bus
);
   localparam logic CPOL = (SPI_MODE >= 2);
   localparam logic CPHA = (SPI_MODE % 2 == 1);

   logic       r_Clk_s1, r_Clk_s2, r_Clk_s3;
   logic       r_CS_s1, r_CS_s2, r_CS_s3;
   logic       r_MOSI_s1, r_MOSI_s2;
   logic       r_Sel;
   logic [2:0] r_Bit_Cnt, r_Trail_Cnt;
   logic [6:0] r_RX_Shift;
   logic [7:0] r_RX_Byte, r_TX_Shift, r_TX_Hold;
   logic       r_RX_DV, r_TX_Full, r_Underrun, r_MISO;

   logic w_Act, w_CS_Fall, w_Lead, w_Trail, w_Sample, w_Load;

   // CS sync regs reset to "active" so a fall is only seen after CS has been observed high,
   // which keeps a transfer interrupted by reset from being picked up mid-byte.
   assign w_Act     = r_Sel & ~r_CS_s2;
   assign w_CS_Fall = r_CS_s3 & ~r_CS_s2;
   assign w_Lead    = w_Act & (r_Clk_s3 == CPOL) & (r_Clk_s2 != CPOL);
   assign w_Trail   = w_Act & (r_Clk_s3 != CPOL) & (r_Clk_s2 == CPOL);
   assign w_Sample  = CPHA ? w_Trail : w_Lead;
   assign w_Load    = w_CS_Fall | (w_Trail & (r_Trail_Cnt == 3'd7));

   // Synchronize SPI pins into i_Clk and track the armed chip-select window
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         {r_Clk_s1, r_Clk_s2, r_Clk_s3} <= {3{CPOL}};
         {r_CS_s1, r_CS_s2, r_CS_s3}    <= 3'b000;
         {r_MOSI_s1, r_MOSI_s2}         <= 2'b00;
         r_Sel                          <= 1'b0;
      end else begin
         {r_Clk_s1, r_Clk_s2, r_Clk_s3} <= {bus.i_SPI_Clk, r_Clk_s1, r_Clk_s2};
         {r_CS_s1, r_CS_s2, r_CS_s3}    <= {bus.i_SPI_CS_n, r_CS_s1, r_CS_s2};
         {r_MOSI_s1, r_MOSI_s2}         <= {bus.i_SPI_MOSI, r_MOSI_s1};
         r_Sel                          <= w_CS_Fall | (r_Sel & ~r_CS_s2);
      end
   end

   // Shift in MOSI on sample edges and publish each completed byte
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Bit_Cnt  <= 3'd0;
         r_RX_Shift <= 7'd0;
         r_RX_Byte  <= 8'h00;
         r_RX_DV    <= 1'b0;
      end else begin
         r_RX_DV <= w_Sample & (r_Bit_Cnt == 3'd7);
         if (!w_Act) r_Bit_Cnt <= 3'd0;
         else if (w_Sample) begin
            r_Bit_Cnt  <= r_Bit_Cnt + 3'd1;
            r_RX_Shift <= {r_RX_Shift[5:0], r_MOSI_s2};
            if (r_Bit_Cnt == 3'd7) r_RX_Byte <= {r_RX_Shift, r_MOSI_s2};
         end
      end
   end

   // Holding register, TX shifter reload at load points, and MISO drive
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_TX_Hold   <= 8'h00;
         r_TX_Full   <= 1'b0;
         r_TX_Shift  <= 8'h00;
         r_Underrun  <= 1'b0;
         r_Trail_Cnt <= 3'd0;
         r_MISO      <= 1'b0;
      end else begin
         r_TX_Hold  <= bus.i_TX_DV ? bus.i_TX_Byte : r_TX_Hold;
         r_TX_Full  <= bus.i_TX_DV | (r_TX_Full & ~w_Load);
         r_Underrun <= w_Load & ~r_TX_Full;
         r_Trail_Cnt <= !w_Act ? 3'd0 : w_Trail ? r_Trail_Cnt + 3'd1 : r_Trail_Cnt;
         if (w_Load) r_TX_Shift <= r_TX_Full ? r_TX_Hold : DEFAULT_TX;
         else if (CPHA ? w_Lead : w_Trail) r_TX_Shift <= {r_TX_Shift[6:0], 1'b0};
         if (!CPHA || w_Lead) r_MISO <= r_TX_Shift[7];
      end
   end

   assign bus.o_SPI_MISO    = r_MISO;
   assign bus.o_SPI_MISO_En = w_Act;
   assign bus.o_CS_Active   = w_Act;
   assign bus.o_TX_Ready    = ~r_TX_Full;
   assign bus.o_TX_Underrun = r_Underrun;
   assign bus.o_RX_DV       = r_RX_DV;
   assign bus.o_RX_Byte     = r_RX_Byte;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bit-banged SPI master against mode 0, 1 and 3 responders
`timescale 1ns/1ps
module tb_spi_slave;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic [2:0] cs_n = 3'b111;
   logic [2:0] tx_dv = 3'b000;
   logic [7:0] tx_byte [3] = '{8'h00, 8'h00, 8'h00};
   logic [2:0] miso, en, csa, rdy, ur, dv;
   logic [7:0] rxb [3];
   int         dv_cnt [3] = '{0, 0, 0};
   int         ur_cnt [3] = '{0, 0, 0};
   logic [7:0] q3 [$];
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   // index 0: mode 0 (DEFAULT_TX FF), index 1: mode 1, index 2: mode 3
   spi_slave_if b0 ();
   spi_slave_if b1 ();
   spi_slave_if b3 ();

   spi_slave #(.SPI_MODE(0), .DEFAULT_TX(8'hFF)) u0 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(b0));
   spi_slave #(.SPI_MODE(1), .DEFAULT_TX(8'h00)) u1 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(b1));
   spi_slave #(.SPI_MODE(3), .DEFAULT_TX(8'h00)) u3 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(b3));

   assign b0.i_SPI_Clk = sclk;  assign b1.i_SPI_Clk = sclk;  assign b3.i_SPI_Clk = sclk;
   assign b0.i_SPI_MOSI = mosi; assign b1.i_SPI_MOSI = mosi; assign b3.i_SPI_MOSI = mosi;
   assign b0.i_SPI_CS_n = cs_n[0]; assign b1.i_SPI_CS_n = cs_n[1]; assign b3.i_SPI_CS_n = cs_n[2];
   assign b0.i_TX_DV = tx_dv[0]; assign b1.i_TX_DV = tx_dv[1]; assign b3.i_TX_DV = tx_dv[2];
   assign b0.i_TX_Byte = tx_byte[0]; assign b1.i_TX_Byte = tx_byte[1]; assign b3.i_TX_Byte = tx_byte[2];
   assign miso = {b3.o_SPI_MISO, b1.o_SPI_MISO, b0.o_SPI_MISO};
   assign en   = {b3.o_SPI_MISO_En, b1.o_SPI_MISO_En, b0.o_SPI_MISO_En};
   assign csa  = {b3.o_CS_Active, b1.o_CS_Active, b0.o_CS_Active};
   assign rdy  = {b3.o_TX_Ready, b1.o_TX_Ready, b0.o_TX_Ready};
   assign ur   = {b3.o_TX_Underrun, b1.o_TX_Underrun, b0.o_TX_Underrun};
   assign dv   = {b3.o_RX_DV, b1.o_RX_DV, b0.o_RX_DV};
   assign rxb[0] = b0.o_RX_Byte;
   assign rxb[1] = b1.o_RX_Byte;
   assign rxb[2] = b3.o_RX_Byte;

   // Count strobe cycles so a stretched pulse shows up as an extra count
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (dv[k] === 1'b1) dv_cnt[k] <= dv_cnt[k] + 1;
         if (ur[k] === 1'b1) ur_cnt[k] <= ur_cnt[k] + 1;
      end
      if (dv[2] === 1'b1) q3.push_back(rxb[2]);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_tx(input int k, input logic [7:0] b);
      @(negedge clk);
      tx_byte[k] = b;
      tx_dv[k] = 1'b1;
      @(negedge clk);
      tx_dv[k] = 1'b0;
   endtask

   task automatic idle(input int m);
      sclk = (m >= 2);
      tick(4);
   endtask

   task automatic cs(input int k, input logic v);
      @(negedge clk);
      cs_n[k] = v;
      tick(8);
   endtask

   task automatic xfer(input int k, input int m, input logic [7:0] tx, input int nb, output logic [7:0] rx);
      logic cpol, cpha;
      cpol = (m >= 2);
      cpha = (m % 2 == 1);
      rx = 8'h00;
      for (int i = 7; i > 7 - nb; i--) begin
         if (!cpha) begin
            mosi = tx[i]; tick(8);
            sclk = ~cpol; rx[i] = miso[k]; tick(8);
            sclk = cpol;
         end else begin
            sclk = ~cpol; mosi = tx[i]; tick(8);
            sclk = cpol; rx[i] = miso[k]; tick(8);
         end
      end
      if (!cpha) tick(8);
   endtask

   task automatic test_reset;
      tick(3);
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if ({miso[k], en[k], csa[k], rdy[k], ur[k], dv[k], rxb[k]} !== {6'b000100, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_values dut%0d: got %b required %b", k,
                     {miso[k], en[k], csa[k], rdy[k], ur[k], dv[k], rxb[k]}, {6'b000100, 8'h00});
         end
      end
      rst_n = 1'b1;
      tick(10);
   endtask

   task automatic test_mode0_basic;
      logic [7:0] rx;
      idle(0);
      load_tx(0, 8'hC3);
      n_chk++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL m0_ready_after_load: got %b required 0", rdy[0]); end
      cs(0, 1'b0);
      n_chk++; if ({rdy[0], csa[0], en[0]} !== 3'b111) begin n_fail++; $display("FAIL m0_ready_cs_en: got %b required 111", {rdy[0], csa[0], en[0]}); end
      n_chk++; if (ur_cnt[0] !== 0) begin n_fail++; $display("FAIL m0_no_underrun_at_cs: got %0d required 0", ur_cnt[0]); end
      xfer(0, 0, 8'hA5, 8, rx);
      n_chk++; if (rx !== 8'hC3) begin n_fail++; $display("FAIL m0_miso_byte: got %h required c3", rx); end
      n_chk++; if (rxb[0] !== 8'hA5) begin n_fail++; $display("FAIL m0_rx_byte: got %h required a5", rxb[0]); end
      n_chk++; if (dv_cnt[0] !== 1) begin n_fail++; $display("FAIL m0_rx_dv_count: got %0d required 1", dv_cnt[0]); end
      n_chk++; if (ur_cnt[0] !== 1) begin n_fail++; $display("FAIL m0_underrun_end_of_byte: got %0d required 1", ur_cnt[0]); end
      cs(0, 1'b1);
      n_chk++; if ({csa[0], en[0]} !== 2'b00) begin n_fail++; $display("FAIL m0_en_drop: got %b required 00", {csa[0], en[0]}); end
   endtask

   task automatic test_underrun;
      logic [7:0] rx;
      cs(0, 1'b0);
      n_chk++; if (ur_cnt[0] !== 2) begin n_fail++; $display("FAIL ur_pulse_at_cs: got %0d required 2", ur_cnt[0]); end
      xfer(0, 0, 8'h00, 8, rx);
      n_chk++; if (rx !== 8'hFF) begin n_fail++; $display("FAIL ur_default_byte: got %h required ff", rx); end
      n_chk++; if (rxb[0] !== 8'h00 || dv_cnt[0] !== 2) begin n_fail++; $display("FAIL ur_rx: got %h/%0d required 00/2", rxb[0], dv_cnt[0]); end
      cs(0, 1'b1);
   endtask

   task automatic test_abort;
      logic [7:0] rx;
      cs(0, 1'b0);
      xfer(0, 0, 8'hC8, 5, rx);
      cs(0, 1'b1);
      n_chk++; if (dv_cnt[0] !== 2) begin n_fail++; $display("FAIL abort_no_dv: got %0d required 2", dv_cnt[0]); end
      cs(0, 1'b0);
      xfer(0, 0, 8'h5A, 8, rx);
      cs(0, 1'b1);
      n_chk++; if (dv_cnt[0] !== 3 || rxb[0] !== 8'h5A) begin n_fail++; $display("FAIL abort_next_byte: got %0d/%h required 3/5a", dv_cnt[0], rxb[0]); end
   endtask

   task automatic test_mode3_multi;
      logic [7:0] rx;
      idle(3);
      load_tx(2, 8'h11);
      cs(2, 1'b0);
      n_chk++; if (rdy[2] !== 1'b1) begin n_fail++; $display("FAIL m3_ready_at_cs: got %b required 1", rdy[2]); end
      load_tx(2, 8'h22);
      xfer(2, 3, 8'h01, 8, rx);
      n_chk++; if (rx !== 8'h11) begin n_fail++; $display("FAIL m3_miso0: got %h required 11", rx); end
      n_chk++; if (rdy[2] !== 1'b1) begin n_fail++; $display("FAIL m3_ready_b1: got %b required 1", rdy[2]); end
      load_tx(2, 8'h33);
      xfer(2, 3, 8'h02, 8, rx);
      n_chk++; if (rx !== 8'h22) begin n_fail++; $display("FAIL m3_miso1: got %h required 22", rx); end
      xfer(2, 3, 8'h03, 8, rx);
      n_chk++; if (rx !== 8'h33) begin n_fail++; $display("FAIL m3_miso2: got %h required 33", rx); end
      cs(2, 1'b1);
      n_chk++; if (dv_cnt[2] !== 3 || q3.size() != 3) begin n_fail++; $display("FAIL m3_dv_count: got %0d/%0d required 3/3", dv_cnt[2], q3.size()); end
      else begin
         n_chk++; if ({q3[0], q3[1], q3[2]} !== 24'h010203) begin n_fail++; $display("FAIL m3_rx_order: got %h required 010203", {q3[0], q3[1], q3[2]}); end
      end
      n_chk++; if (ur_cnt[2] !== 1) begin n_fail++; $display("FAIL m3_underrun_last: got %0d required 1", ur_cnt[2]); end
   endtask

   task automatic test_cs_inactive;
      int c0, c1, c2;
      idle(0);
      c0 = dv_cnt[0]; c1 = dv_cnt[1]; c2 = dv_cnt[2];
      for (int i = 0; i < 16; i++) begin
         mosi = i[0];
         sclk = ~sclk;
         tick(5);
      end
      tick(6);
      n_chk++; if (dv_cnt[0] != c0 || dv_cnt[1] != c1 || dv_cnt[2] != c2) begin n_fail++; $display("FAIL idle_edges_dv: got %0d,%0d,%0d required %0d,%0d,%0d", dv_cnt[0], dv_cnt[1], dv_cnt[2], c0, c1, c2); end
      n_chk++; if (en !== 3'b000) begin n_fail++; $display("FAIL idle_edges_en: got %b required 000", en); end
   endtask

   task automatic test_reset_midbyte;
      logic [7:0] rx;
      int c1;
      idle(1);
      load_tx(1, 8'hE7);
      cs(1, 1'b0);
      xfer(1, 1, 8'h3C, 8, rx);
      n_chk++; if (rx !== 8'hE7 || rxb[1] !== 8'h3C) begin n_fail++; $display("FAIL m1_byte: got %h/%h required e7/3c", rx, rxb[1]); end
      cs(1, 1'b1);
      cs(1, 1'b0);
      xfer(1, 1, 8'hFF, 3, rx);
      c1 = dv_cnt[1];
      rst_n = 1'b0;
      tick(2);
      n_chk++;
      if ({miso[1], en[1], csa[1], rdy[1], ur[1], dv[1], rxb[1]} !== {6'b000100, 8'h00}) begin
         n_fail++;
         $display("FAIL midbyte_reset_values: got %b required %b",
                  {miso[1], en[1], csa[1], rdy[1], ur[1], dv[1], rxb[1]}, {6'b000100, 8'h00});
      end
      rst_n = 1'b1;
      tick(4);
      for (int i = 0; i < 16; i++) begin
         mosi = 1'b1;
         sclk = ~sclk;
         tick(8);
      end
      n_chk++; if (dv_cnt[1] != c1 || csa[1] !== 1'b0) begin n_fail++; $display("FAIL post_reset_ignore: got %0d/%b required %0d/0", dv_cnt[1], csa[1], c1); end
      cs(1, 1'b1);
      cs(1, 1'b0);
      xfer(1, 1, 8'h96, 8, rx);
      cs(1, 1'b1);
      n_chk++; if (rxb[1] !== 8'h96 || dv_cnt[1] != c1 + 1) begin n_fail++; $display("FAIL post_reset_byte: got %h/%0d required 96/%0d", rxb[1], dv_cnt[1], c1 + 1); end
      n_chk++; if (rx !== 8'h00) begin n_fail++; $display("FAIL post_reset_miso: got %h required 00", rx); end
   endtask

   initial begin
      test_reset;
      test_mode0_basic;
      test_underrun;
      test_abort;
      test_mode3_multi;
      test_cs_inactive;
      test_reset_midbyte;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder (slave) for the sensor-side link: it receives bytes on MOSI and returns bytes on MISO under an externally driven SPI clock and chip-select. The block oversamples all SPI pins in the i_Clk domain, so no second clock domain exists inside it. It presents a byte-level handshake to the local logic: an RX data-valid pulse, and a TX holding register with a ready flag. It is the counterpart to the team's SPI master and supports the same four SPI modes.

## Interface
- SPI_MODE, 0: 0..3. CPOL is 1 for modes 2 and 3. CPHA is 1 for modes 1 and 3.
- DEFAULT_TX, 8'h00: byte shifted out when no TX byte is pending (underrun).

- i_Clk  in  1  system clock; must be ≥ 8× the SPI clock frequency.
- i_Rst_L  in  1  reset, asynchronous, active-low; clock i_Clk.
- i_SPI_Clk  in  1  SPI clock from the master (asynchronous).
- i_SPI_CS_n  in  1  chip-select, active-low (asynchronous).
- i_SPI_MOSI  in  1  master-out data (asynchronous).
- o_SPI_MISO  out  1  slave-out data.
- o_SPI_MISO_En  out  1  tri-state enable for MISO; high while CS is active (synchronized).
- i_TX_DV  in  1  one-cycle pulse; loads i_TX_Byte into the holding register.
- i_TX_Byte  in  8  next byte to send.
- o_TX_Ready  out  1  holding register empty.
- o_TX_Underrun  out  1  one-cycle pulse when DEFAULT_TX is used.
- o_RX_DV  out  1  one-cycle pulse; o_RX_Byte is valid.
- o_RX_Byte  out  8  last complete received byte, MSB first.
- o_CS_Active  out  1  synchronized CS status.

## Operation
- **Synchronizers:** SCLK, CS_n and MOSI each pass through a 2-flop synchronizer. SCLK gets a third register for edge detection.
  - Leading edge: synchronized SCLK leaves the CPOL level.
  - Trailing edge: synchronized SCLK returns to the CPOL level.
  - Edges are ignored while CS is inactive.
- **Sample edge:** leading edge when CPHA=0, trailing edge when CPHA=1. Each sample edge shifts synchronized MOSI into rx_shift, MSB first, and increments a 3-bit bit counter.
- **End of byte:** the 8th sample edge writes o_RX_Byte, pulses o_RX_DV and wraps the counter to 0. Multi-byte transfers under one CS assertion continue without gaps.
- **TX load point:** CS activation, and each 8th trailing edge of a byte.
  - If the holding register is full, tx_shift loads it and o_TX_Ready rises.
  - If the holding register is empty, tx_shift loads DEFAULT_TX and o_TX_Underrun pulses.
- **MISO, CPHA=0:** o_SPI_MISO = tx_shift[7]. Trailing edges 1–7 shift left.
- **MISO, CPHA=1:** on each leading edge, o_SPI_MISO ← tx_shift[7], then tx_shift shifts left.
- **Holding register:**
  - i_TX_DV writes it and clears o_TX_Ready.
  - i_TX_DV while already full overwrites the pending byte.
  - i_TX_DV in the same cycle as a load point: the old held byte moves to tx_shift, the new byte is held, and o_TX_Ready stays 0.
- **CS deassert mid-byte:**
  - Partial RX bits are discarded; no o_RX_DV.
  - The bit counter resets.
  - The holding register is retained.
  - o_SPI_MISO_En drops.
- **Reset:** async reset mid-transfer clears all state. The block resynchronizes on the next CS activation; edges seen before that are ignored.

## Timing
- **Reset values:**
  - o_SPI_MISO = 0, o_SPI_MISO_En = 0, o_CS_Active = 0.
  - o_TX_Ready = 1, o_TX_Underrun = 0.
  - o_RX_DV = 0, o_RX_Byte = 8'h00.
  - Internal SCLK registers reset to CPOL.
- **Pin-to-detect latency:** 3 i_Clk cycles (2 sync + 1 detect register).
- **o_RX_DV:** high on the i_Clk cycle after detection of the 8th sample edge, i.e. 3–4 cycles after the pin edge. Exactly one cycle wide.
- **MISO after CS fall (CPHA=0):** valid 4 cycles after CS falls. The master must allow ≥ 4 i_Clk between CS fall and the first SCLK edge.
- **MISO after a shift edge:** updates 4 cycles after the pin edge. A half SCLK period of ≥ 4 i_Clk meets master setup.
- **o_TX_Ready:** rises in the cycle after a load point that consumed the held byte.

## Test plan
- **Mode 0 basic:** preload 0xC3, CS low, master sends 0xA5 → o_RX_Byte = 0xA5 with a single o_RX_DV; master reads 0xC3; o_TX_Ready rises after the load at CS.
- **Mode 3, 3 bytes:** TX 0x11/0x22/0x33 fed on each o_TX_Ready; master sends 0x01/0x02/0x03 → three o_RX_DV pulses in order; master reads 0x11, 0x22, 0x33.
- **Underrun:** no preload, DEFAULT_TX = 0xFF → master reads 0xFF; o_TX_Underrun pulses once at CS activation.
- **Abort:** CS high after 5 bits, then a full byte 0x5A → exactly one o_RX_DV, with value 0x5A.
- **Edges while CS inactive:** SCLK toggles with CS high → no o_RX_DV; o_SPI_MISO_En = 0.
- **Reset mid-byte:** reset after 3 bits of mode 1 → all outputs at reset values; the next transfer of 0x96 is received correctly.
